// File: rtl/cnn_pkg.sv
// Shared CNN types and sizing for the conv/pool back end and the feature serialiser.
// Also provides the kernel-to-lane mapping used on the upstream data lanes.
package cnn_pkg;

  localparam int unsigned BitSize            = 8;
  localparam int unsigned NumberOfK          = 8;
  localparam int unsigned ProcessingElements = 2;
  localparam int unsigned OutWidth           = 2;

  localparam int unsigned PixPerImage = OutWidth * OutWidth;
  localparam int unsigned IdxW        = (NumberOfK > 1) ? $clog2(NumberOfK) : 1;
  localparam int unsigned PixW        = (PixPerImage > 1) ? $clog2(PixPerImage) : 1;
  localparam int unsigned LaneW       = (ProcessingElements > 1) ? $clog2(ProcessingElements) : 1;

  typedef logic [BitSize-1:0] pixel_t;
  typedef pixel_t [NumberOfK-1:0] kvec_t;

  // Kernel k is carried on upstream lane k % ProcessingElements.
  function automatic int unsigned lane_of(input int unsigned k);
    return k % ProcessingElements;
  endfunction

endpackage

// File: rtl/feature_bank.sv
// One pixel buffer of the serialiser: NumberOfK feature registers, fill mask and full flag.
// fill_c flags that this edge's strobes complete the pixel.
module feature_bank
  import cnn_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      res,
  input  logic                                      wr_en,
  input  logic [NumberOfK-1:0]                      in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0] in_data,
  input  logic                                      release_en,
  input  logic [IdxW-1:0]                           rd_idx,
  output logic                                      full,
  output logic                                      fill_c,
  output pixel_t                                    rd_data_c
);

  logic [NumberOfK-1:0] mask;
  logic [NumberOfK-1:0] strobe_c;
  logic [NumberOfK-1:0] mask_next_c;
  kvec_t                mem;

  always_comb begin
    strobe_c    = wr_en ? in_valid : '0;
    mask_next_c = mask | strobe_c;
    fill_c      = wr_en && !full && (&mask_next_c);
    rd_data_c   = mem[rd_idx];
  end

  // Fill tracking; a bank is only filled while empty and only released while full.
  always_ff @(posedge clk) begin
    if (res) begin
      mask <= '0;
      full <= 1'b0;
    end else begin
      if (fill_c) mask <= '0;
      else        mask <= mask_next_c;
      if (fill_c)          full <= 1'b1;
      else if (release_en) full <= 1'b0;
    end
  end

  // Feature storage needs no reset; duplicate strobes simply overwrite.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NumberOfK; k++) begin
      if (strobe_c[IdxW'(k)]) mem[IdxW'(k)] <= in_data[LaneW'(lane_of(k))];
    end
  end

endmodule

// File: rtl/feature_serialiser.sv
// Double-buffered collector of per-kernel results, drained one element per cycle in
// kernel order. Define FEATURE_SERIALISER_RELU_EN to clamp negative outputs to zero.
module feature_serialiser
  import cnn_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      res,
  input  logic [NumberOfK-1:0]                      in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0] in_data,
  output logic                                      in_ready,
  output logic                                      out_valid,
  output logic [BitSize-1:0]                        out_data,
  output logic                                      out_last,
  input  logic                                      out_ready
);

  logic            wr;
  logic            rd;
  logic [IdxW-1:0] idx;
  logic [PixW-1:0] pix;

  logic [1:0] full;
  logic [1:0] fill_c;
  logic [1:0] wr_en_c;
  logic [1:0] release_c;
  pixel_t     rd_data0_c;
  pixel_t     rd_data1_c;
  pixel_t     stored_c;
  logic       take_c;
  logic       last_elem_c;
  logic       last_pix_c;

  feature_bank u_bank0 (
    .clk        (clk),
    .res        (res),
    .wr_en      (wr_en_c[0]),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .release_en (release_c[0]),
    .rd_idx     (idx),
    .full       (full[0]),
    .fill_c     (fill_c[0]),
    .rd_data_c  (rd_data0_c)
  );

  feature_bank u_bank1 (
    .clk        (clk),
    .res        (res),
    .wr_en      (wr_en_c[1]),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .release_en (release_c[1]),
    .rd_idx     (idx),
    .full       (full[1]),
    .fill_c     (fill_c[1]),
    .rd_data_c  (rd_data1_c)
  );

  // Handshake decode and output gating, all from registered state.
  always_comb begin
    in_ready    = !(full[0] && full[1]);
    out_valid   = full[rd];
    last_elem_c = (idx == IdxW'(NumberOfK - 1));
    last_pix_c  = (pix == PixW'(PixPerImage - 1));
    take_c      = out_valid && out_ready;
    wr_en_c     = '0;
    wr_en_c[wr] = in_ready;
    release_c     = '0;
    release_c[rd] = take_c && last_elem_c;
    stored_c    = rd ? rd_data1_c : rd_data0_c;
`ifdef FEATURE_SERIALISER_RELU_EN
    out_data    = (out_valid && !stored_c[BitSize-1]) ? stored_c : '0;
`else
    out_data    = out_valid ? stored_c : '0;
`endif
    out_last    = out_valid && last_elem_c && last_pix_c;
  end

  // Write/read bank pointers, element index and per-image pixel count.
  always_ff @(posedge clk) begin
    if (res) begin
      wr  <= 1'b0;
      rd  <= 1'b0;
      idx <= '0;
      pix <= '0;
    end else begin
      if (fill_c[wr]) wr <= ~wr;
      if (take_c) begin
        if (last_elem_c) begin
          idx <= '0;
          rd  <= ~rd;
          pix <= last_pix_c ? '0 : pix + PixW'(1);
        end else begin
          idx <= idx + IdxW'(1);
        end
      end
    end
  end

endmodule
